perf_counter_csr_ctrl: RTL and testbench
========================================

// Module: perf_counter_csr_ctrl
// PURPOSE
//  CSR-side controller for the core's hardware performance monitor.
//  Owns mcycle, minstret and four programmable counters (mhpmcounter3..6), each with an event-select CSR.
//  Serialises CSR read/write requests from the CSR unit over a valid/ready request and response handshake.
//  Applies mcountinhibit and flags counter overflow.
//  Sits between the CSR unit and the pipeline's event strobes.
// PARAMETERS
//  CTR_W     64  counter width; legal range 33..64; hi-half CSRs return bits [CTR_W-1:32], zero-extended
//  NUM_HPM   4   programmable counters, fixed at indices 3..6 (legal range 1..4)
// PORTS
//  clk            in   1    clock
//  reset          in   1    reset, synchronous, active-high
//  evt_i          in   5    event strobes [0]retire [1]br_taken [2]br_miss [3]load_use_stall [4]div_stall
//  req_valid      in   1    CSR request valid
//  req_ready      out  1    controller can accept a request (high only in IDLE)
//  req_we         in   1    1=write, 0=read
//  req_addr       in   12   CSR address
//  req_wdata      in   32   write data
//  rsp_valid      out  1    response valid
//  rsp_ready      in   1    response consumed
//  rsp_rdata      out  32   read data (0 for writes and errors)
//  rsp_err        out  1    unmapped address
//  ovf_irq        out  1    overflow interrupt (PERF_OVF_IRQ_EN only)
// BEHAVIOUR
//  Address map:
//   mcycle B00/B80 (lo/hi); minstret B02/B82; mhpmcounterN B0N/B8N, N=3..6.
//   mhpmeventN 32N: 3-bit select; 0=off, 1..5 -> evt_i[sel-1], 6..7 never count.
//   mcountinhibit 320: bits [0],[2],[6:3] writable; bit 1 reads 0.
//  Reset values: all counters, event selects and mcountinhibit 0; req_ready 1; rsp_valid/rsp_rdata/rsp_err/ovf_irq 0.
//  FSM IDLE -> EXEC -> RESP:
//   IDLE: req_valid&&req_ready accepts the request in cycle T and registers addr/we/wdata.
//   EXEC (T+1): decode; perform the write or latch the read data.
//   RESP (from T+2): rsp_valid held with stable rsp_rdata/rsp_err until rsp_ready; return to IDLE the same cycle.
//   Back-to-back: the next request is accepted no earlier than the cycle after the handshake, i.e. at most one request per 3 cycles.
//  Counting: every cycle, each non-inhibited counter adds 1 if its event is active.
//   mcycle counts every cycle; minstret counts evt_i[0].
//  Write vs increment: a CSR write in EXEC overrides that counter's increment that cycle.
//   Writing the lo half replaces bits [31:0]; writing the hi half replaces bits [CTR_W-1:32]; the other half is unchanged.
//  Atomic 64-bit read: a lo-half read latches the counter's upper bits into a shadow register.
//   A hi read immediately following that lo read (same counter, no other request in between) returns the shadow.
//   Any other hi read returns live bits.
//  Wrap-around: all-ones + 1 -> 0 and sets that counter's ovf bit (7 bits; index 1 unused).
//  Unmapped address, or a write to a read-only bit: rsp_err=1 only for unmapped addresses; read-only bits are silently ignored.
//  Reset mid-transaction: FSM -> IDLE, rsp_valid drops next edge, any in-flight write discarded.
// CONFIGURATION
//  PERF_OVF_IRQ_EN defined:
//   CSR 7C0 is mhpmovf: read = ovf bits; write-1-to-clear.
//   CSR 7C1 is ovf enable mask, reset 0.
//   ovf_irq = |(ovf & mask), registered (1 cycle after the wrap).
//   A wrap in the same cycle as a W1C of that bit leaves the bit set.
//  PERF_OVF_IRQ_EN undefined:
//   No ovf/mask state; 7C0/7C1 respond rsp_err=1; ovf_irq tied 0.
// TESTING
//  1. Reset, then read B00 with rsp_ready=1 -> rsp_valid at T+2, rdata 2..3 (cycle count), err=0; req_ready low T+1..T+2.
//  2. Write 323=2, pulse evt_i[1] 10 times, read B03 -> 10; set 320 bit3, pulse 5 more -> still 10.
//  3. Write B83=0xFFFFFFFF and B03=0xFFFFFFFE, pulse evt_i[1] twice -> counter 0.
//     With PERF_OVF_IRQ_EN: 7C0 bit3=1 and, with mask bit3 set, ovf_irq=1; write 7C0=8 -> irq 0.
//  4. Read B02 (lo) while minstret crosses 0x0000_0000_FFFF_FFFF -> a following B82 read returns the shadowed hi=0.
//     A separate fresh hi read returns 1.
//  5. Hold rsp_ready=0 for 4 cycles -> rsp_valid/rdata stable, req_ready=0; read of 0x123 -> err=1, rdata 0.
//  6. Assert reset during EXEC of a write to B03=0x55 -> counter remains 0, rsp_valid never asserts.

Source files
------------

// File: rtl/perf_counter_csr_ctrl.sv
// perf_counter_csr_ctrl
//   CSR-side controller for the hardware performance monitor. Owns mcycle,
//   minstret and NUM_HPM programmable counters (mhpmcounter3..), each with a
//   3-bit event select, plus mcountinhibit. CSR requests are serialised through
//   an IDLE -> EXEC -> RESP sequence with valid/ready on both request and
//   response sides.
//
//   Optional feature macro: PERF_OVF_IRQ_EN
//     defined   : mhpmovf (0x7C0, W1C) and overflow enable mask (0x7C1) exist;
//                 ovf_irq = registered |(ovf & mask).
//     undefined : 0x7C0/0x7C1 are unmapped, ovf_irq is tied low.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   evt_i[4:0]      event strobes: retire, br_taken, br_miss, load_use_stall, div_stall
//   req_valid/ready request handshake; req_ready is high only in IDLE
//   req_we/addr/wdata  request payload
//   rsp_valid/ready response handshake
//   rsp_rdata/err   read data (0 on writes/errors), unmapped-address flag
//   ovf_irq         overflow interrupt
module perf_counter_csr_ctrl #(
  parameter int CTR_W   = 64,
  parameter int NUM_HPM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  evt_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ovf_irq
);

  localparam int HI_W = CTR_W - 32;
  localparam int NCTR = 7;
  // Counter slots that exist: 0 (mcycle), 2 (minstret), 3..2+NUM_HPM.
  // The same pattern is the writable mask of mcountinhibit and the ovf mask.
  localparam logic [6:0] CTR_MASK = 7'b0000101 | 7'(((1 << NUM_HPM) - 1) << 3);
  localparam logic [7:0] IMPL     = {1'b0, CTR_MASK};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
  typedef enum logic [2:0] {K_NONE, K_LO, K_HI, K_SEL, K_INH, K_OVF, K_OVF_EN} kind_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [11:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CTR_W-1:0]  ctr_q [NCTR];
  logic [CTR_W-1:0]  ctr_d [NCTR];
  logic [2:0]        sel_q [NCTR];
  logic [2:0]        sel_d [NCTR];
  logic [6:0]        inh_q, inh_d;
  logic [HI_W-1:0]   shadow_q, shadow_d;
  logic [2:0]        shadow_idx_q, shadow_idx_d;
  logic              shadow_vld_q, shadow_vld_d;

  logic [NCTR-1:0]   cnt_en;
  logic [NCTR-1:0]   wrap;
  kind_e             dec_kind;
  logic [2:0]        dec_idx;
  logic [CTR_W-1:0]  rd_ctr;
  logic [2:0]        sel_rd;
  logic [HI_W-1:0]   rd_hi;

`ifdef PERF_OVF_IRQ_EN
  logic [6:0]        ovf_q, ovf_d;
  logic [6:0]        ovf_en_q, ovf_en_d;
  logic              ovf_irq_q, ovf_irq_d;
`endif

  function automatic logic ev_active(input logic [2:0] sel, input logic [4:0] evt);
    logic act;
    act = 1'b0;
    case (sel)
      3'd1:    act = evt[0];
      3'd2:    act = evt[1];
      3'd3:    act = evt[2];
      3'd4:    act = evt[3];
      3'd5:    act = evt[4];
      default: act = 1'b0;  // 0 = off, 6..7 never count
    endcase
    return act;
  endfunction

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dec_idx   = addr_q[2:0];

  // Address decode of the registered request (used in EXEC)
  always_comb begin
    dec_kind = K_NONE;
    if (addr_q[11:3] == 9'h160 && IMPL[addr_q[2:0]])
      dec_kind = K_LO;
    else if (addr_q[11:3] == 9'h170 && IMPL[addr_q[2:0]])
      dec_kind = K_HI;
    else if (addr_q == 12'h320)
      dec_kind = K_INH;
    else if (addr_q[11:3] == 9'h064 && addr_q[2:0] >= 3'd3 && IMPL[addr_q[2:0]])
      dec_kind = K_SEL;
`ifdef PERF_OVF_IRQ_EN
    else if (addr_q == 12'h7C0)
      dec_kind = K_OVF;
    else if (addr_q == 12'h7C1)
      dec_kind = K_OVF_EN;
`endif
  end

  always_comb begin
    rd_ctr = '0;
    sel_rd = '0;
    for (int i = 0; i < NCTR; i++) begin
      if (dec_idx == 3'(i)) begin
        rd_ctr = ctr_q[i];
        sel_rd = sel_q[i];
      end
    end
  end

  always_comb begin
    cnt_en    = '0;
    cnt_en[0] = 1'b1;
    cnt_en[2] = evt_i[0];
    for (int i = 3; i < NCTR; i++) cnt_en[i] = ev_active(sel_q[i], evt_i);
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    inh_d        = inh_q;
    shadow_d     = shadow_q;
    shadow_idx_d = shadow_idx_q;
    shadow_vld_d = shadow_vld_q;
    rd_hi        = '0;

    // Free-running increment; a CSR write below overrides it for its counter
    for (int i = 0; i < NCTR; i++) begin
      ctr_d[i] = ctr_q[i];
      sel_d[i] = sel_q[i];
      wrap[i]  = 1'b0;
      if (IMPL[i] && cnt_en[i] && !inh_q[i]) begin
        ctr_d[i] = ctr_q[i] + CTR_W'(1);
        wrap[i]  = &ctr_q[i];
      end
    end

    case (state_q)
      // IDLE: capture the request
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          we_d        = req_we;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          state_d     = S_EXEC;
        end
      end

      // EXEC: perform the write or latch the read data
      S_EXEC: begin
        state_d      = S_RESP;
        rsp_valid_d  = 1'b1;
        rsp_err_d    = (dec_kind == K_NONE);
        rsp_rdata_d  = '0;
        // Any request other than the lo read itself breaks the lo/hi pairing
        shadow_vld_d = 1'b0;
        if (we_q) begin
          case (dec_kind)
            K_LO, K_HI: begin
              for (int i = 0; i < NCTR; i++) begin
                if (dec_idx == 3'(i)) begin
                  if (dec_kind == K_LO) ctr_d[i] = {ctr_q[i][CTR_W-1:32], wdata_q};
                  else                  ctr_d[i] = {wdata_q[HI_W-1:0], ctr_q[i][31:0]};
                  wrap[i] = 1'b0;
                end
              end
            end
            K_SEL: begin
              for (int i = 0; i < NCTR; i++) begin
                if (dec_idx == 3'(i)) sel_d[i] = wdata_q[2:0];
              end
            end
            K_INH:   inh_d = wdata_q[6:0] & CTR_MASK;
            default: ;
          endcase
        end else begin
          case (dec_kind)
            K_LO: begin
              rsp_rdata_d  = rd_ctr[31:0];
              shadow_d     = rd_ctr[CTR_W-1:32];
              shadow_idx_d = dec_idx;
              shadow_vld_d = 1'b1;
            end
            K_HI: begin
              if (shadow_vld_q && shadow_idx_q == dec_idx) rd_hi = shadow_q;
              else                                          rd_hi = rd_ctr[CTR_W-1:32];
              rsp_rdata_d = 32'(rd_hi);
            end
            K_SEL:    rsp_rdata_d = 32'(sel_rd);
            K_INH:    rsp_rdata_d = 32'(inh_q);
`ifdef PERF_OVF_IRQ_EN
            K_OVF:    rsp_rdata_d = 32'(ovf_q);
            K_OVF_EN: rsp_rdata_d = 32'(ovf_en_q);
`endif
            default:  rsp_rdata_d = '0;
          endcase
        end
      end

      // RESP: hold the response until it is consumed
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      inh_q        <= '0;
      shadow_q     <= '0;
      shadow_idx_q <= '0;
      shadow_vld_q <= 1'b0;
      for (int i = 0; i < NCTR; i++) begin
        ctr_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      inh_q        <= inh_d;
      shadow_q     <= shadow_d;
      shadow_idx_q <= shadow_idx_d;
      shadow_vld_q <= shadow_vld_d;
      for (int i = 0; i < NCTR; i++) begin
        ctr_q[i] <= ctr_d[i];
        sel_q[i] <= sel_d[i];
      end
    end
  end

`ifdef PERF_OVF_IRQ_EN
  always_comb begin
    ovf_d    = ovf_q;
    ovf_en_d = ovf_en_q;
    if (state_q == S_EXEC && we_q && dec_kind == K_OVF)
      ovf_d = ovf_q & ~wdata_q[6:0];
    if (state_q == S_EXEC && we_q && dec_kind == K_OVF_EN)
      ovf_en_d = wdata_q[6:0] & CTR_MASK;
    // Applied after the clear so a same-cycle wrap keeps its bit set
    ovf_d     = ovf_d | wrap;
    ovf_irq_d = |(ovf_q & ovf_en_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q     <= '0;
      ovf_en_q  <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_en_q  <= ovf_en_d;
      ovf_irq_q <= ovf_irq_d;
    end
  end

  assign ovf_irq = ovf_irq_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
  assign ovf_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_csr_ctrl.sv
// Bench for perf_counter_csr_ctrl: directed scenarios plus randomized CSR
// traffic and random event strobes, checked against a per-cycle behavioural
// model of the counters and CSRs.
module tb_perf_counter_csr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  evt_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ovf_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  perf_counter_csr_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .evt_i     (evt_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ovf_irq   (ovf_irq)
  );

  // Reference model state
  logic [63:0] m_ctr [7];
  logic [2:0]  m_sel [7];
  logic [6:0]  m_inh, m_ovf, m_mask;
  logic        m_irq;
  logic        m_sh_vld;
  int          m_sh_idx;
  logic [31:0] m_sh_val;
  int          pend_kind;   // 0 none, 1 lo, 2 hi, 3 inhibit, 4 select, 5 ovf clear, 6 ovf mask
  int          pend_idx;
  logic [31:0] pend_val;

  bit          evt_rand;
  logic [4:0]  evt_val;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_ctr(input int i);
    return (i == 0) || (i == 2) || (i >= 3 && i <= 6);
  endfunction

  function automatic bit counts(input int i, input logic [4:0] ev);
    if (m_inh[i]) return 1'b0;
    if (i == 0) return 1'b1;
    if (i == 2) return ev[0];
    if (m_sel[i] >= 3'd1 && m_sel[i] <= 3'd5) return ev[int'(m_sel[i]) - 1];
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      m_ctr[i] = '0;
      m_sel[i] = '0;
    end
    m_inh = '0; m_ovf = '0; m_mask = '0; m_irq = 1'b0;
    m_sh_vld = 1'b0; m_sh_idx = 0; m_sh_val = '0;
    pend_kind = 0; pend_idx = 0; pend_val = '0;
  endtask

  task automatic model_edge(input logic [4:0] ev);
    logic [6:0] wrapped;
    logic       next_irq;
    wrapped  = '0;
    next_irq = |(m_ovf & m_mask);
    for (int i = 0; i < 7; i++) begin
      if (!is_ctr(i)) continue;
      if (pend_kind == 1 && pend_idx == i)      m_ctr[i][31:0]  = pend_val;
      else if (pend_kind == 2 && pend_idx == i) m_ctr[i][63:32] = pend_val;
      else if (counts(i, ev)) begin
        if (m_ctr[i] == 64'hFFFF_FFFF_FFFF_FFFF) wrapped[i] = 1'b1;
        m_ctr[i] = m_ctr[i] + 64'd1;
      end
    end
    case (pend_kind)
      3: m_inh  = pend_val[6:0] & 7'h7D;
      4: m_sel[pend_idx] = pend_val[2:0];
      5: m_ovf  = m_ovf & ~pend_val[6:0];
      6: m_mask = pend_val[6:0] & 7'h7D;
      default: ;
    endcase
    m_ovf     = m_ovf | wrapped;
    m_irq     = next_irq;
    pend_kind = 0;
  endtask

  // Expected response of a request about to execute; schedules its write
  task automatic model_exec(input bit we, input logic [11:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    int  idx;
    bit  sh_keep;
    rd = '0; er = 1'b0; sh_keep = 1'b0;
    if (a >= 12'hB00 && a <= 12'hB06 && is_ctr(int'(a - 12'hB00))) begin
      idx = int'(a - 12'hB00);
      if (we) begin pend_kind = 1; pend_idx = idx; pend_val = wd; end
      else begin
        rd = m_ctr[idx][31:0];
        m_sh_val = m_ctr[idx][63:32]; m_sh_idx = idx; sh_keep = 1'b1;
      end
    end else if (a >= 12'hB80 && a <= 12'hB86 && is_ctr(int'(a - 12'hB80))) begin
      idx = int'(a - 12'hB80);
      if (we) begin pend_kind = 2; pend_idx = idx; pend_val = wd; end
      else rd = (m_sh_vld && m_sh_idx == idx) ? m_sh_val : m_ctr[idx][63:32];
    end else if (a == 12'h320) begin
      if (we) begin pend_kind = 3; pend_val = wd; end
      else rd = {25'd0, m_inh};
    end else if (a >= 12'h323 && a <= 12'h326) begin
      idx = int'(a - 12'h320);
      if (we) begin pend_kind = 4; pend_idx = idx; pend_val = wd; end
      else rd = {29'd0, m_sel[idx]};
`ifdef PERF_OVF_IRQ_EN
    end else if (a == 12'h7C0) begin
      if (we) begin pend_kind = 5; pend_val = wd; end
      else rd = {25'd0, m_ovf};
    end else if (a == 12'h7C1) begin
      if (we) begin pend_kind = 6; pend_val = wd; end
      else rd = {25'd0, m_mask};
`endif
    end else begin
      er = 1'b1;
    end
    m_sh_vld = sh_keep;
  endtask

  task automatic step();
    if (evt_rand) evt_i = 5'($urandom);
    else          evt_i = evt_val;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(evt_i);
    #1;
`ifdef PERF_OVF_IRQ_EN
    check("ovf_irq", {63'd0, ovf_irq}, {63'd0, m_irq});
`else
    check("ovf_irq_tied", {63'd0, ovf_irq}, 64'd0);
`endif
  endtask

  task automatic xact(input bit we, input logic [11:0] a, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
    step();                                   // accept edge T
    req_valid = 1'b0;
    check("req_ready_t1", {63'd0, req_ready}, 64'd0);
    check("rsp_valid_t1", {63'd0, rsp_valid}, 64'd0);
    model_exec(we, a, wd, exp_rd, exp_er);
    step();                                   // EXEC edge
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rd});
      check("rsp_err",   {63'd0, rsp_err},   {63'd0, exp_er});
      check("req_ready_resp", {63'd0, req_ready}, 64'd0);
      rd = rsp_rdata; er = rsp_err;
      step();
    end
    rsp_ready = 1'b0;
    check("rsp_valid_done", {63'd0, rsp_valid}, 64'd0);
  endtask

  logic [11:0] addr_tbl [24] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                                  12'hB80, 12'hB82, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
                                  12'h320, 12'h323, 12'h324, 12'h325, 12'h326,
                                  12'h7C0, 12'h7C1,
                                  12'hB01, 12'hB81, 12'h321, 12'h327, 12'h123};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; evt_rand = 1'b0; evt_val = '0; evt_i = '0;
    model_reset();
    repeat (3) step();
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
    check("rst_ovf_irq",   {63'd0, ovf_irq},   64'd0);
    reset = 1'b0;
    step();

    // 1: mcycle read right after reset
    xact(1'b0, 12'hB00, 32'd0, 0, rd, er);
    check("t1_mcycle_range", {63'd0, (rd >= 32'd2 && rd <= 32'd3)}, 64'd1);
    check("t1_err", {63'd0, er}, 64'd0);

    // 2: event select and inhibit
    xact(1'b1, 12'h323, 32'd2, 0, rd, er);
    evt_val = 5'b00010; repeat (10) step(); evt_val = '0;
    xact(1'b0, 12'hB03, 32'd0, 0, rd, er);
    check("t2_count10", {32'd0, rd}, 64'd10);
    xact(1'b1, 12'h320, 32'd8, 0, rd, er);
    evt_val = 5'b00010; repeat (5) step(); evt_val = '0;
    xact(1'b0, 12'hB03, 32'd0, 0, rd, er);
    check("t2_inhibited", {32'd0, rd}, 64'd10);
    xact(1'b1, 12'h320, 32'h0000_0002, 0, rd, er);
    xact(1'b0, 12'h320, 32'd0, 0, rd, er);
    check("t2_inh_bit1_ro", {32'd0, rd}, 64'd0);

    // 3: wrap-around and overflow
    xact(1'b1, 12'hB83, 32'hFFFF_FFFF, 0, rd, er);
    xact(1'b1, 12'hB03, 32'hFFFF_FFFE, 0, rd, er);
    evt_val = 5'b00010; repeat (2) step(); evt_val = '0;
    xact(1'b0, 12'hB03, 32'd0, 0, rd, er);
    check("t3_wrap_lo", {32'd0, rd}, 64'd0);
    xact(1'b0, 12'hB83, 32'd0, 0, rd, er);
    check("t3_wrap_hi", {32'd0, rd}, 64'd0);
`ifdef PERF_OVF_IRQ_EN
    xact(1'b0, 12'h7C0, 32'd0, 0, rd, er);
    check("t3_ovf_bit3", {63'd0, rd[3]}, 64'd1);
    xact(1'b1, 12'h7C1, 32'd8, 0, rd, er);
    check("t3_irq_set", {63'd0, ovf_irq}, 64'd1);
    xact(1'b1, 12'h7C0, 32'd8, 0, rd, er);
    check("t3_irq_clr", {63'd0, ovf_irq}, 64'd0);
`else
    xact(1'b0, 12'h7C0, 32'd0, 0, rd, er);
    check("t3_7c0_err", {63'd0, er}, 64'd1);
    check("t3_7c0_rdata", {32'd0, rd}, 64'd0);
`endif

    // 4: lo/hi shadow across a carry into the upper half
    xact(1'b1, 12'hB82, 32'd0, 0, rd, er);
    xact(1'b1, 12'hB02, 32'hFFFF_FFFF, 0, rd, er);
    xact(1'b0, 12'hB02, 32'd0, 0, rd, er);
    check("t4_lo", {32'd0, rd}, 64'hFFFF_FFFF);
    evt_val = 5'b00001; repeat (3) step(); evt_val = '0;
    xact(1'b0, 12'hB82, 32'd0, 0, rd, er);
    check("t4_hi_shadow", {32'd0, rd}, 64'd0);
    xact(1'b0, 12'hB82, 32'd0, 0, rd, er);
    check("t4_hi_live", {32'd0, rd}, 64'd1);

    // 5: response back-pressure and unmapped address
    xact(1'b0, 12'hB03, 32'd0, 4, rd, er);
    xact(1'b0, 12'h123, 32'd0, 4, rd, er);
    check("t5_err", {63'd0, er}, 64'd1);
    check("t5_rdata0", {32'd0, rd}, 64'd0);
    xact(1'b1, 12'h123, 32'hDEAD_BEEF, 1, rd, er);
    check("t5_werr", {63'd0, er}, 64'd1);

    // Randomized traffic with random event strobes
    evt_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [11:0] a;
      logic [31:0] wd;
      a  = addr_tbl[$urandom_range(0, 23)];
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 | (wd & 32'hF);
      if (a == 12'h320 && $urandom_range(0, 1) == 1) wd = '0;
      xact(1'($urandom_range(0, 1)), a, wd, $urandom_range(0, 3), rd, er);
    end
    evt_rand = 1'b0;

    // 6: reset lands on the EXEC edge of a write
    xact(1'b1, 12'h320, 32'd0, 0, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'hB03; req_wdata = 32'h55;
    step();
    req_valid = 1'b0;
    check("t6_accepted", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rsp_dropped", {63'd0, rsp_valid}, 64'd0);
    check("t6_ready_back", {63'd0, req_ready}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    xact(1'b0, 12'hB03, 32'd0, 0, rd, er);
    check("t6_ctr_zero", {32'd0, rd}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
